// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
// otter_pkg
// Shared control-state type and RV32I opcode/funct3 constants for the OTTER.
// Rev 1.0
// ============================================================================
package otter_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        INTR  = 3'd4
    } cu_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_MRET  = 3'b000;

endpackage
`default_nettype wire

// File: rtl/otter_cu_fsm.sv
`default_nettype none
// ============================================================================
// otter_cu_fsm
// Multicycle control FSM: fetch/execute/writeback sequencing, interrupt entry
// and the retired-instruction counter.
// Rev 1.0
// ============================================================================
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           ir_opcode,
    input  logic [2:0]           ir_funct3,
    input  logic                 intr,
    input  logic                 csr_mie,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 mem_rden1,
    output logic                 mem_rden2,
    output logic                 mem_we2,
    output logic                 rst_out,
    output logic                 csr_we,
    output logic                 int_taken,
    output logic                 mret_exec,
    output logic [INSTRET_W-1:0] instret
);

    cu_state_t            state_q;
    cu_state_t            state_d;
    logic [INSTRET_W-1:0] instret_q;
    logic                 retire;

    // Outputs are Mealy: the EXEC and WB enables depend on the live opcode
    // and mem_ready, so a waiting WB cycle never writes anything.
    always_comb begin
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        rst_out   = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        retire    = 1'b0;
        state_d   = state_q;

        unique case (state_q)
            INIT: begin
                rst_out = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                mem_rden1 = 1'b1;
                if (mem_ready) state_d = EXEC;
            end
            EXEC: begin
                case (ir_opcode)
                    OPC_LOAD: begin
                        mem_rden2 = 1'b1;
                        state_d   = WB;
                    end
                    OPC_STORE: begin
                        mem_we2  = 1'b1;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    OPC_SYS: begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        if (ir_funct3 == F3_CSRRW) begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                        end else if (ir_funct3 == F3_MRET) begin
                            mret_exec = 1'b1;
                        end
                    end
                    OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                        retire    = 1'b1;
                    end
                    // Branches and unrecognised opcodes only advance the PC.
                    default: begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                endcase
            end
            WB: begin
                mem_rden2 = 1'b1;
                if (mem_ready) begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                end
            end
            INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = INIT;
        endcase

        // Interrupts are only taken on an instruction boundary.
        if (retire) state_d = (intr && csr_mie) ? INTR : FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign instret = instret_q;

`ifndef SYNTHESIS
    a_mem_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_we2 && mem_rden2));
    a_int_excl: assert property (@(posedge clk) disable iff (!rst_n) !(int_taken && reg_write));
`endif

endmodule
`default_nettype wire
